// File: rtl/simplediv.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Uses a valid/ready handshake on both the operand input and the result output.
module simplediv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] qreg_nxt;

  // One extra bit keeps the trial subtract exact when the shifted remainder overflows WIDTH.
  always_comb begin
    rem_sh   = {rem_q, qreg_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, div_q};
    ge       = ~trial[WIDTH];
    rem_nxt  = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    qreg_nxt = {qreg_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    qreg_d  = qreg_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (b == '0) begin
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            div_d   = b;
            qreg_d  = a;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d  = rem_nxt;
        qreg_d = qreg_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          q_d     = qreg_nxt;
          r_d     = rem_nxt;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      qreg_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      qreg_q  <= qreg_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_simplediv.sv
// Directed-vector bench for simplediv: table of operand/result records plus
// hand-written sequences for backpressure, busy-time input changes and async reset.
module tb_simplediv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  int nvec = 0;
  int nerr = 0;

  simplediv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one operation and samples #1 after each edge until the block is idle again.
  task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                       output logic [31:0] qo, output logic [31:0] ro, output logic dbo,
                       output int lat, output int irl);
    int n;
    @(negedge clk);
    a = ai;
    b = bi;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    irl = 0;
    qo  = '0;
    ro  = '0;
    dbo = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (out_valid && lat == 0) begin
        lat = k;
        qo  = q;
        ro  = r;
        dbo = dbz;
      end
      if (in_ready) break;
      irl++;
    end
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] rq, rr;
    logic        rd;
    int          lat, irl;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0};
    vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,    1'b0};
    vecs[4] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1};
    vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0};
    vecs[6] = '{32'd1000,       32'd3,          32'd333,        32'd1,    1'b0};
    vecs[7] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,    1'b0};
    vecs[8] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,    1'b1};
    vecs[9] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q",         q,         0);
    chk("rst_r",         r,         0);
    chk("rst_dbz",       dbz,       0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, rq, rr, rd, lat, irl);
      chk($sformatf("vec%0d_q", i),   rq, vecs[i].q);
      chk($sformatf("vec%0d_r", i),   rr, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), rd, vecs[i].dbz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].dbz ? 1 : 33);
      chk($sformatf("vec%0d_inready_low", i), irl, vecs[i].dbz ? 1 : 33);
    end

    // Backpressure: result held while out_ready is low, new operands wait for the handshake.
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'd1000;
    b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd7;
    b = 32'd2;
    wait_valid(100);
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_q",     q,         333);
      chk("bp_hold_r",     r,         1);
      chk("bp_in_ready",   in_ready,  0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", in_ready,  1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_retain_q",   q,         333);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_next", in_ready, 0);
    wait_valid(100);
    chk("bp_next_q", q, 3);
    chk("bp_next_r", r, 1);
    repeat (2) @(posedge clk);

    // Operand changes while busy are ignored.
    @(negedge clk);
    a = 32'd1000;
    b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd7;
    b = 32'd2;
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(100);
    chk("busy_chg_valid", out_valid, 1);
    chk("busy_chg_q",     q,         333);
    chk("busy_chg_r",     r,         1);
    repeat (3) @(posedge clk);

    // Async reset in the middle of a division.
    @(negedge clk);
    a = 32'd1000;
    b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  in_ready,  1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_q",         q,         0);
    chk("arst_r",         r,         0);
    chk("arst_dbz",       dbz,       0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd50, 32'd5, rq, rr, rd, lat, irl);
    chk("arst_after_q",   rq,  10);
    chk("arst_after_r",   rr,  0);
    chk("arst_after_lat", lat, 33);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 5 == 0) ra = ra >> 16;
      if (rb == 0) rb = 32'd1;
      do_op(ra, rb, rq, rr, rd, lat, irl);
      chk("rand_identity", {32'd0, rq} * {32'd0, rb} + {32'd0, rr}, {32'd0, ra});
      chk("rand_r_lt_b",   (rr < rb), 1);
      chk("rand_lat",      lat, 33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
